// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI write-only register file feeding the PWM block
//
// Purpose: oversamples a write-only SPI bus in the clk domain and holds the five
// 8-bit PWM control registers. Frames are 16 bits, MSB first:
// {rw, addr[6:0], data[7:0]}.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   sclk, copi, ncs  SPI pins, asynchronous to clk (ncs active-low)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   wr_commit        one-clk pulse when a valid write lands
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_commit
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // After reset the synchronizers hold ncs=1 while the pin may already be
    // low. Edge detection stays disarmed until the chain and the history
    // flops have been refilled from the pins. Without this, a frame that was
    // already in flight when reset released would show a false nCS fall.
    localparam int            FW      = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FLUSH_N = FW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_hist_q;
    logic                   ncs_hist_q;
    logic [FW-1:0]          flush_q;

    logic                   sclk_s;
    logic                   copi_s;
    logic                   ncs_s;
    logic                   armed;
    logic                   sclk_rise;
    logic                   ncs_fall;
    logic                   ncs_rise;

    state_t                 state_q;
    logic [4:0]             bit_cnt_q;
    logic [15:0]            shift_q;
    logic [7:0]             reg0_q;
    logic [7:0]             reg1_q;
    logic [7:0]             reg2_q;
    logic [7:0]             reg3_q;
    logic [7:0]             reg4_q;
    logic                   wr_commit_q;
    logic                   commit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            flush_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
            if (!armed) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign armed     = (flush_q == FLUSH_N);
    assign sclk_rise = armed & sclk_s & ~sclk_hist_q;
    assign ncs_fall  = armed & ~ncs_s & ncs_hist_q;
    assign ncs_rise  = armed & ncs_s & ~ncs_hist_q;

    assign commit_ok = (bit_cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    // The register write and wr_commit are issued on the edge that leaves
    // SHIFT. This lands them SYNC_STAGES+1 edges after ncs is first sampled
    // high. COMMIT is the cycle in which wr_commit is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            reg3_q      <= '0;
            reg4_q      <= '0;
            wr_commit_q <= 1'b0;
        end else begin
            wr_commit_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ncs_fall) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // ncs rise wins over a coincident sclk rise.
                    if (ncs_rise) begin
                        state_q <= S_COMMIT;
                        if (commit_ok) begin
                            wr_commit_q <= 1'b1;
                            case (shift_q[14:8])
                                7'h00:   reg0_q <= shift_q[7:0];
                                7'h01:   reg1_q <= shift_q[7:0];
                                7'h02:   reg2_q <= shift_q[7:0];
                                7'h03:   reg3_q <= shift_q[7:0];
                                7'h04:   reg4_q <= shift_q[7:0];
                                default: ;
                            endcase
                        end
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[14:0], copi_s};
                        // Saturate at 17: anything past 16 bits is an overrun.
                        if (bit_cnt_q != 5'd17) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    // Accept a back-to-back frame without losing its nCS fall.
                    if (ncs_fall) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        state_q   <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = reg0_q;
    assign en_reg_out_15_8 = reg1_q;
    assign en_reg_pwm_7_0  = reg2_q;
    assign en_reg_pwm_15_8 = reg3_q;
    assign pwm_duty_cycle  = reg4_q;
    assign wr_commit       = wr_commit_q;

endmodule
